// File: rtl/dorm_lock_pkg.sv
// Shared definitions for the dorm lock keypad: digit format and the sequencer state encoding.
package dorm_lock_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTRY   = 2'd1,
      CHECK   = 2'd2,
      LOCKOUT = 2'd3
   } lock_state_t;

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return d <= BCD_MAX;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero; done is high whenever the count is zero.
module lock_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/access_code_sequencer.sv
// Keypad access-code sequencer: collects BCD digits, compares against the stored code,
// pulses the result and locks out after repeated failures.
module access_code_sequencer
   import dorm_lock_pkg::*;
#(
   parameter int CODE_DIGITS    = 4,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int ENTRY_TIMEOUT  = 500,
   parameter logic [4*CODE_DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         digit_valid,
   input  logic [DIGIT_W-1:0]           digit,
   input  logic                         clear,
   input  logic                         code_load,
   input  logic [DIGIT_W*CODE_DIGITS-1:0] new_code,
   output logic                         door_status_correct,
   output logic                         door_status_incorrect,
   output logic                         locked_out,
   output logic                         entry_active,
   output lock_state_t                  state_dbg,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_count_dbg
);

   localparam int CODE_W    = DIGIT_W * CODE_DIGITS;
   localparam int TIMER_MAX = (LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
   localparam int CNT_W     = $clog2(CODE_DIGITS + 1);
   localparam int FAIL_W    = $clog2(MAX_FAILS + 1);

   // The timer reads zero on the last cycle of each interval, hence the minus one.
   localparam logic [TIMER_W-1:0] ENTRY_LOAD = TIMER_W'(ENTRY_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(CODE_DIGITS - 1);
   localparam logic [FAIL_W-1:0]  FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);
   localparam logic [FAIL_W-1:0]  FAIL_SAT   = FAIL_W'(MAX_FAILS);

   lock_state_t         state, next_state;
   logic [CODE_W-1:0]   entry_reg, entry_next;
   logic [CODE_W-1:0]   stored_code, code_next;
   logic [CNT_W-1:0]    digit_count, count_next;
   logic [FAIL_W-1:0]   fail_count, fail_next;
   logic                correct_next, incorrect_next;
   logic                timer_load, timer_done;
   logic [TIMER_W-1:0]  timer_value;
   logic                digit_ok;

   lock_timer #(.WIDTH(TIMER_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   always_comb begin
      next_state     = state;
      entry_next     = entry_reg;
      count_next     = digit_count;
      fail_next      = fail_count;
      code_next      = stored_code;
      correct_next   = 1'b0;
      incorrect_next = 1'b0;
      timer_load     = 1'b0;
      timer_value    = ENTRY_LOAD;
      digit_ok       = digit_valid && is_bcd(digit);

      case (state)
         IDLE: begin
            if (digit_ok) begin
               entry_next = CODE_W'(digit);
               count_next = CNT_W'(1);
               timer_load = 1'b1;
               next_state = (CODE_DIGITS == 1) ? CHECK : ENTRY;
            end else if (code_load && !digit_valid) begin
               code_next = new_code;
            end
         end
         ENTRY: begin
            // clear outranks a digit arriving in the same cycle
            if (clear) begin
               count_next = '0;
               next_state = IDLE;
            end else if (digit_ok) begin
               entry_next = (entry_reg << DIGIT_W) | CODE_W'(digit);
               count_next = digit_count + CNT_W'(1);
               timer_load = 1'b1;
               if (digit_count == LAST_IDX) begin
                  next_state = CHECK;
               end
            end else if (timer_done) begin
               count_next = '0;
               next_state = IDLE;
            end
         end
         CHECK: begin
            count_next = '0;
            if (entry_reg == stored_code) begin
               correct_next = 1'b1;
               fail_next    = '0;
               next_state   = IDLE;
            end else begin
               incorrect_next = 1'b1;
               if (fail_count >= FAIL_LAST) begin
                  fail_next   = FAIL_SAT;
                  timer_load  = 1'b1;
                  timer_value = LOCK_LOAD;
                  next_state  = LOCKOUT;
               end else begin
                  fail_next  = fail_count + FAIL_W'(1);
                  next_state = IDLE;
               end
            end
         end
         LOCKOUT: begin
            if (timer_done) begin
               fail_next  = '0;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                 <= IDLE;
         entry_reg             <= '0;
         digit_count           <= '0;
         fail_count            <= '0;
         stored_code           <= DEFAULT_CODE;
         door_status_correct   <= 1'b0;
         door_status_incorrect <= 1'b0;
         locked_out            <= 1'b0;
         entry_active          <= 1'b0;
      end else begin
         state                 <= next_state;
         entry_reg             <= entry_next;
         digit_count           <= count_next;
         fail_count            <= fail_next;
         stored_code           <= code_next;
         door_status_correct   <= correct_next;
         door_status_incorrect <= incorrect_next;
         locked_out            <= (next_state == LOCKOUT);
         entry_active          <= (next_state == ENTRY) || (next_state == CHECK);
      end
   end

   assign state_dbg      = state;
   assign fail_count_dbg = fail_count;

endmodule

// File: tb/tb_access_code_sequencer.sv
// Directed bench for access_code_sequencer: expected result pulses are queued when a code is
// keyed in and popped when the result cycle arrives.
module tb_access_code_sequencer;
   import dorm_lock_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        digit_valid;
   logic [3:0]  digit;
   logic        clear;
   logic        code_load;
   logic [15:0] new_code;
   logic        door_status_correct;
   logic        door_status_incorrect;
   logic        locked_out;
   logic        entry_active;
   lock_state_t state_dbg;
   logic [1:0]  fail_count_dbg;

   int checks = 0;
   int errors = 0;
   int pulses_seen = 0;
   int pulses_exp = 0;
   logic [1:0] exp_q[$];

   access_code_sequencer dut (
      .clk                   (clk),
      .reset                 (reset),
      .digit_valid           (digit_valid),
      .digit                 (digit),
      .clear                 (clear),
      .code_load             (code_load),
      .new_code              (new_code),
      .door_status_correct   (door_status_correct),
      .door_status_incorrect (door_status_incorrect),
      .locked_out            (locked_out),
      .entry_active          (entry_active),
      .state_dbg             (state_dbg),
      .fail_count_dbg        (fail_count_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_digit(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      tick();
      digit_valid = 1'b0;
   endtask

   // exp: {incorrect, correct}
   task automatic send_code(input logic [15:0] code, input logic [1:0] exp,
                            input logic clear_in_check, input string tag);
      logic [1:0] got_exp;
      for (int i = 3; i >= 0; i--) begin
         digit_valid = 1'b1;
         digit       = code[i*4 +: 4];
         tick();
      end
      digit_valid = 1'b0;
      exp_q.push_back(exp);
      pulses_exp++;
      check({tag, " check_state"}, 32'(state_dbg), 32'(CHECK));
      check({tag, " active_in_check"}, 32'(entry_active), 32'd1);
      clear = clear_in_check;
      tick();
      clear = 1'b0;
      got_exp = exp_q.pop_front();
      check({tag, " pulse"}, 32'({door_status_incorrect, door_status_correct}), 32'(got_exp));
      tick();
      check({tag, " one_cycle"}, 32'({door_status_incorrect, door_status_correct}), 32'd0);
   endtask

   // Pulse monitor: counts every result pulse and checks mutual exclusion.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (door_status_correct || door_status_incorrect) pulses_seen++;
         check("exclusive", 32'(door_status_correct & door_status_incorrect), 32'd0);
      end
   end

   initial begin
      int n;
      reset       = 1'b1;
      digit_valid = 1'b1;
      digit       = 4'd1;
      clear       = 1'b0;
      code_load   = 1'b0;
      new_code    = 16'h0000;
      tick(); tick(); tick();
      check("reset outputs", 32'({door_status_correct, door_status_incorrect, locked_out, entry_active}), 32'd0);
      check("reset state", 32'(state_dbg), 32'(IDLE));
      check("reset fails", 32'(fail_count_dbg), 32'd0);
      reset       = 1'b0;
      digit_valid = 1'b0;
      tick();
      check("post reset outputs", 32'({door_status_correct, door_status_incorrect, locked_out, entry_active}), 32'd0);

      // Default code
      send_code(16'h1234, 2'b01, 1'b0, "basic");
      check("basic fails", 32'(fail_count_dbg), 32'd0);

      // Three wrong codes into lockout
      send_code(16'h0000, 2'b10, 1'b0, "wrong1");
      check("wrong1 fails", 32'(fail_count_dbg), 32'd1);
      send_code(16'h0000, 2'b10, 1'b0, "wrong2");
      check("wrong2 fails", 32'(fail_count_dbg), 32'd2);
      send_code(16'h0000, 2'b10, 1'b0, "wrong3");
      check("lockout flag", 32'(locked_out), 32'd1);
      check("lockout state", 32'(state_dbg), 32'(LOCKOUT));
      check("lockout fails sat", 32'(fail_count_dbg), 32'd3);
      n = 1;
      while (locked_out === 1'b1 && n < 2000) begin
         n++;
         digit_valid = 1'($urandom_range(0, 1));
         digit       = 4'($urandom_range(0, 15));
         clear       = 1'($urandom_range(0, 1));
         code_load   = 1'($urandom_range(0, 1));
         new_code    = 16'($urandom);
         tick();
      end
      digit_valid = 1'b0;
      clear       = 1'b0;
      code_load   = 1'b0;
      check("lockout length", 32'(n), 32'd1000);
      check("no pulse in lockout", 32'(pulses_seen), 32'(pulses_exp));
      check("after lockout state", 32'(state_dbg), 32'(IDLE));
      check("after lockout fails", 32'(fail_count_dbg), 32'd0);
      send_code(16'h1234, 2'b01, 1'b0, "post_lockout");

      // Code change
      new_code  = 16'h9876;
      code_load = 1'b1;
      tick();
      code_load = 1'b0;
      send_code(16'h1234, 2'b10, 1'b0, "old_code");
      send_code(16'h9876, 2'b01, 1'b1, "new_code_clear_in_check");
      check("new code fails", 32'(fail_count_dbg), 32'd0);
      // code_load alongside a digit is not honored; the digit starts an entry
      new_code    = 16'h1111;
      code_load   = 1'b1;
      drive_digit(4'd5);
      code_load   = 1'b0;
      check("load with digit entry", 32'(entry_active), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear entry", 32'(entry_active), 32'd0);
      send_code(16'h9876, 2'b01, 1'b0, "code_kept");

      // Entry timeout, with an out-of-range digit that must not restart it
      send_code(16'h0000, 2'b10, 1'b0, "pre_timeout");
      drive_digit(4'd1);
      drive_digit(4'd2);
      for (int i = 0; i < 499; i++) begin
         if (i == 250) begin
            digit_valid = 1'b1;
            digit       = 4'd12;
         end
         tick();
         digit_valid = 1'b0;
      end
      check("timeout last cycle", 32'(state_dbg), 32'(ENTRY));
      tick();
      check("timeout state", 32'(state_dbg), 32'(IDLE));
      check("timeout active", 32'(entry_active), 32'd0);
      check("timeout fails kept", 32'(fail_count_dbg), 32'd1);
      send_code(16'h9876, 2'b01, 1'b0, "after_timeout");

      // Restore default, clear beats digit, invalid digit ignored, reset mid-entry
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive_digit(4'd1);
      drive_digit(4'd2);
      digit_valid = 1'b1;
      digit       = 4'd3;
      clear       = 1'b1;
      tick();
      digit_valid = 1'b0;
      clear       = 1'b0;
      check("clear wins", 32'(state_dbg), 32'(IDLE));
      drive_digit(4'd12);
      check("digit 12 ignored", 32'(entry_active), 32'd0);
      send_code(16'h1234, 2'b01, 1'b0, "after_clear");
      new_code  = 16'h5555;
      code_load = 1'b1;
      tick();
      code_load = 1'b0;
      drive_digit(4'd1);
      drive_digit(4'd2);
      drive_digit(4'd3);
      reset = 1'b1;
      tick();
      check("mid reset outputs", 32'({door_status_correct, door_status_incorrect, locked_out, entry_active}), 32'd0);
      check("mid reset state", 32'(state_dbg), 32'(IDLE));
      reset = 1'b0;
      tick();
      send_code(16'h1234, 2'b01, 1'b0, "restored_code");

      tick(); tick();
      check("total pulses", 32'(pulses_seen), 32'(pulses_exp));
      check("queue empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
